mult4_seq_ctrl: RTL and testbench

Multi-cycle unsigned 4x4 multiplier controller. It time-shares one combinational 2x2-bit multiplier unit across four partial products, then shifts and accumulates them into an 8-bit product. It sits between the switch/button input logic and the display path. It replaces a full-width array multiplier with one small shared unit plus an FSM.

---
 rtl/mult4_pkg.sv | 42 ++++
 rtl/mul2x2.sv | 13 +
 rtl/mult4_seq_ctrl.sv | 106 ++++++++++
 tb/tb_mult4_seq_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mult4_pkg.sv
// mult4_pkg: shared types and constants for the sequential 4x4 multiplier.
//   state_t    - controller states
//   operands_t - latched operand pair
//   NUM_PP     - number of 2x2 partial products per multiply
//   PROD_W     - product / accumulator width
//   PP_SHIFT   - left-shift applied to each partial product, indexed by PP step
package mult4_pkg;

   localparam int OPND_W = 4;
   localparam int DIG_W  = 2;
   localparam int NUM_PP = 4;
   localparam int PROD_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      PP0,
      PP1,
      PP2,
      PP3,
      DONE
   } state_t;

   typedef struct packed {
      logic [OPND_W-1:0] a;
      logic [OPND_W-1:0] b;
   } operands_t;

   // Step k multiplies digit (k[0]) of a by digit (k[1]) of b, so the
   // weight is 2*(k[0]+k[1]) bits: {0, 2, 2, 4}.
   localparam logic [NUM_PP-1:0][2:0] PP_SHIFT = {3'd4, 3'd2, 3'd2, 3'd0};

   // Partial-product step index for a PP state; 0 outside PP0..PP3.
   function automatic logic [1:0] pp_index(input state_t s);
      case (s)
         PP1:     return 2'd1;
         PP2:     return 2'd2;
         PP3:     return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/mul2x2.sv
// mul2x2: combinational unsigned 2x2-bit multiplier shared by all PP steps.
//   x [1:0] - digit of multiplicand
//   y [1:0] - digit of multiplier
//   p [3:0] - x*y (max 9)
module mul2x2 (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic [3:0] p
);

   assign p = {2'b00, x} * {2'b00, y};

endmodule

// File: rtl/mult4_seq_ctrl.sv
// mult4_seq_ctrl: multi-cycle unsigned 4x4 multiplier. One shared 2x2 unit
// produces four partial products over PP0..PP3; they are shifted and summed
// into an 8-bit accumulator, and the result is registered on leaving DONE.
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   start   - request a multiply (sampled in IDLE only)
//   a, b    - unsigned 4-bit operands, latched on the accepted start
//   busy    - high in PP0..PP3
//   done    - one-cycle pulse, coincident with the first cycle product is valid
//   product - registered 8-bit result, held until the next result
module mult4_seq_ctrl
   import mult4_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic              busy,
   output logic              done,
   output logic [PROD_W-1:0] product
);

   state_t            state, state_nxt;
   operands_t         opr;
   logic [PROD_W-1:0] acc;

   logic              load, accum, finish;
   logic [1:0]        pp_sel;
   logic [DIG_W-1:0]  pp_x, pp_y;
   logic [3:0]        pp;
   logic [2:0]        pp_sh;
   logic [PROD_W-1:0] pp_term;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = PP0;
         PP0:     state_nxt = PP1;
         PP1:     state_nxt = PP2;
         PP2:     state_nxt = PP3;
         PP3:     state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs / datapath controls ----------------
   always_comb begin
      busy   = 1'b0;
      load   = 1'b0;
      accum  = 1'b0;
      finish = 1'b0;
      pp_sel = pp_index(state);
      case (state)
         IDLE:           load   = start;
         PP0, PP1,
         PP2, PP3: begin busy   = 1'b1;
                         accum  = 1'b1; end
         DONE:           finish = 1'b1;
         default: ;
      endcase
   end

   // ---------------- operand mux, shared multiplier, shifter ----------------
   // pp_sel[0] picks the high digit of a, pp_sel[1] the high digit of b.
   assign pp_x = pp_sel[0] ? opr.a[3:2] : opr.a[1:0];
   assign pp_y = pp_sel[1] ? opr.b[3:2] : opr.b[1:0];

   mul2x2 u_mul2x2 (
      .x (pp_x),
      .y (pp_y),
      .p (pp)
   );

   assign pp_sh   = PP_SHIFT[pp_sel];
   assign pp_term = {{(PROD_W-4){1'b0}}, pp} << pp_sh;

   // ---------------- operand regs, accumulator, result ----------------
   // done is registered alongside product so the pulse marks the first
   // cycle the new result is visible; this lands in IDLE, never with busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opr     <= '0;
         acc     <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= finish;
         if (load) begin
            opr <= '{a: a, b: b};
            acc <= '0;
         end
         if (accum)  acc     <= acc + pp_term;
         if (finish) product <= acc;
      end
   end

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
module tb_mult4_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       busy, done;
   logic [7:0] product;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   mult4_seq_ctrl dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expected product.
   always @(negedge clk) begin
      if (rst_n && done) begin
         checks++;
         if (busy) begin
            errors++;
            $display("FAIL busy_done_overlap: busy=%0d done=%0d", busy, done);
         end
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: product=%0d with no outstanding multiply", product);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (int'(product) != e) begin
               errors++;
               $display("FAIL product: got %0d expected %0d", product, e);
            end
         end
      end
   end

   // One multiply: issue start for one cycle, optionally scramble live inputs
   // afterwards and/or re-pulse start while busy, then watch a 10-cycle window.
   task automatic run_mul(input logic [3:0] ta, input logic [3:0] tb,
                          input bit perturb, input bit poke);
      int lat, nbusy, ndone;
      @(negedge clk);
      a = ta; b = tb; start = 1'b1;
      exp_q.push_back(int'(ta) * int'(tb));
      lat = -1; nbusy = 0; ndone = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) begin
            start = 1'b0;
            if (perturb) begin a = 4'($urandom); b = 4'($urandom); end
         end
         if (poke) start = (c == 1);
         if (busy) nbusy++;
         if (done) begin
            ndone++;
            if (lat < 0) lat = c;
         end
      end
      chk("latency", lat, 5);
      chk("busy_cycles", nbusy, 4);
      chk("done_count", ndone, 1);
      chk("product_hold", int'(product), int'(ta) * int'(tb));
   endtask

   initial begin
      int dc[$];
      // Reset state
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_product", int'(product), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_mul(4'd3, 4'd5, 1'b0, 1'b0);
      run_mul(4'd15, 4'd15, 1'b0, 1'b0);
      run_mul(4'd0, 4'd9, 1'b0, 1'b0);
      // Inputs changed right after start must not matter
      @(negedge clk); a = 4'd6; b = 4'd7; start = 1'b1;
      exp_q.push_back(42);
      @(negedge clk); start = 1'b0; a = 4'd1; b = 4'd1;
      repeat (9) @(negedge clk);
      chk("latched_operands", int'(product), 42);
      // Start pulsed during PP1 is ignored
      run_mul(4'd6, 4'd7, 1'b1, 1'b1);
      run_mul(4'd1, 4'd1, 1'b0, 1'b0);

      // Randomized operands with scrambled live inputs and idle gaps
      for (int i = 0; i < 20; i++) begin
         run_mul(4'($urandom), 4'($urandom), 1'b1, 1'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Held start: a new multiply every 6 cycles
      @(negedge clk); a = 4'd5; b = 4'd3; start = 1'b1;
      repeat (4) exp_q.push_back(15);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (c == 18) start = 1'b0;
         if (done) dc.push_back(c);
      end
      chk("held_done_count", dc.size(), 4);
      foreach (dc[k]) chk("held_done_cycle", dc[k], 5 + 6 * k);
      chk("held_product", int'(product), 15);

      // Reset in PP2 aborts immediately and issues no done
      @(negedge clk); a = 4'd12; b = 4'd10; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pp2_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_product", int'(product), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_abort_product", int'(product), 0);
      run_mul(4'd2, 4'd2, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
